alu_result_stage: RTL and testbench

- Execute→writeback pipeline stage directly downstream of the 8-bit ALU.
- Captures ALU result, status flags and destination metadata through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Maintains the architectural status register {N,V,C,Z} and evaluates branch conditions from it for the control unit.

---
 rtl/alu_result_stage_pkg.sv | 32 +++
 rtl/alu_result_stage_if.sv | 37 +++
 rtl/alu_result_stage_skid_buffer2.sv | 61 ++++++
 rtl/alu_result_stage.sv | 74 +++++++
 tb/tb_alu_result_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: condition codes, flag bit
// positions and a helper that packs ALU flags into status-register order.
package alu_result_stage_pkg;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_CS = 3'b011;
  localparam logic [2:0] COND_CC = 3'b100;
  localparam logic [2:0] COND_MI = 3'b101;
  localparam logic [2:0] COND_VS = 3'b110;
  localparam logic [2:0] COND_LT = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef logic [3:0] flags_t;

  function automatic flags_t pack_flags(input logic n, input logic v,
                                        input logic c, input logic z);
    flags_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream (ALU) and downstream (writeback) handshake bundle of the result
// stage. master = the environment driving the stage, slave = the stage itself.
interface alu_result_stage_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_WIDTH   = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  in_zero;
  logic                  in_carry;
  logic                  in_overflow;
  logic                  in_negative;
  logic [RD_WIDTH-1:0]   in_rd;
  logic                  in_wr_en;
  logic                  in_flags_en;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [RD_WIDTH-1:0]   out_rd;
  logic                  out_wr_en;

  modport master (
    output in_valid, in_result, in_zero, in_carry, in_overflow, in_negative,
           in_rd, in_wr_en, in_flags_en, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wr_en
  );

  modport slave (
    input  in_valid, in_result, in_zero, in_carry, in_overflow, in_negative,
           in_rd, in_wr_en, in_flags_en, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr_en
  );

endinterface

// File: rtl/alu_result_stage_skid_buffer2.sv
// Generic 2-entry valid/ready FIFO with synchronous flush. in_ready depends
// only on the registered count, so there is no path from out_ready to in_ready.
module skid_buffer2 #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             push;
  logic             pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? slot0 : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_data;
          else               slot1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // count is 1 here (push is blocked at 2), so the new entry becomes head
          if (count == 2'd1) begin
            slot0 <= in_data;
          end else begin
            slot0 <= slot1;
            slot1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: buffers ALU results toward writeback and keeps
// the architectural {N,V,C,Z} status register plus branch condition decode.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_result_stage_if.slave       bus,
  input  logic                    flush,
  output logic [3:0]              status_flags,
  input  logic [2:0]              cond_sel,
  output logic                    cond_true
);

  localparam int PAYLOAD_W = DATA_WIDTH + RD_WIDTH + 1;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 accept;
  flags_t               flags_q;

  assign in_payload = {bus.in_wr_en, bus.in_rd, bus.in_result};

  skid_buffer2 #(
    .WIDTH (PAYLOAD_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_payload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign bus.out_result = out_payload[DATA_WIDTH-1:0];
  assign bus.out_rd     = out_payload[DATA_WIDTH +: RD_WIDTH];
  assign bus.out_wr_en  = out_payload[PAYLOAD_W-1];

  assign accept = bus.in_valid & bus.in_ready;

  // Flags commit at accept even under flush: they belong to the executed op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (accept && bus.in_flags_en) begin
      flags_q <= pack_flags(bus.in_negative, bus.in_overflow,
                            bus.in_carry, bus.in_zero);
    end
  end

  assign status_flags = flags_q;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_sel)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = flags_q[FLAG_Z];
      COND_NE: cond_true = ~flags_q[FLAG_Z];
      COND_CS: cond_true = flags_q[FLAG_C];
      COND_CC: cond_true = ~flags_q[FLAG_C];
      COND_MI: cond_true = flags_q[FLAG_N];
      COND_VS: cond_true = flags_q[FLAG_V];
      COND_LT: cond_true = flags_q[FLAG_N] ^ flags_q[FLAG_V];
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_alu_result_stage;

  typedef struct {
    logic [7:0] r;
    logic [2:0] rd;
    logic       we;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] cond_sel;
  logic [3:0] status_flags;
  logic       cond_true;

  int n_cmp = 0;
  int n_err = 0;

  ent_t       q[$];
  logic [3:0] m_flags;

  alu_result_stage_if #(.DATA_WIDTH(8), .RD_WIDTH(3)) bus ();

  alu_result_stage #(.DATA_WIDTH(8), .RD_WIDTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flush        (flush),
    .status_flags (status_flags),
    .cond_sel     (cond_sel),
    .cond_true    (cond_true)
  );

  always #5 clk = ~clk;

  // Condition table written as a lookup: index = cond_sel.
  function automatic logic cond_ref(input logic [3:0] f, input logic [2:0] sel);
    logic [7:0] tbl;
    logic n, v, c, z;
    n = f[3]; v = f[2]; c = f[1]; z = f[0];
    tbl = {n ^ v, v, n, ~c, c, ~z, z, 1'b1};
    return tbl[sel];
  endfunction

  task automatic set_in(input logic v, input logic [7:0] r, input logic [2:0] rd,
                        input logic we, input logic fe, input logic [3:0] nvcz);
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_rd       = rd;
    bus.in_wr_en    = we;
    bus.in_flags_en = fe;
    bus.in_negative = nvcz[3];
    bus.in_overflow = nvcz[2];
    bus.in_carry    = nvcz[1];
    bus.in_zero     = nvcz[0];
  endtask

  // One clock: model decides from pre-edge inputs, then commits after the edge.
  task automatic cycle();
    bit   acc, pp;
    ent_t e;
    logic [3:0] nf;
    acc = bus.in_valid && (q.size() < 2) && !rst;
    pp  = bus.out_ready && (q.size() > 0) && !rst;
    e.r = bus.in_result; e.rd = bus.in_rd; e.we = bus.in_wr_en;
    nf  = m_flags;
    if (acc && bus.in_flags_en)
      nf = {bus.in_negative, bus.in_overflow, bus.in_carry, bus.in_zero};
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_flags = 4'b0000;
    end else begin
      m_flags = nf;
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    cond_sel = 3'b000;
    bus.out_ready = 1'b0;
    set_in(1'b1, 8'hAA, 3'd5, 1'b1, 1'b1, 4'b1111);
    q.delete();
    m_flags = 4'b0000;
    repeat (2) cycle();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'b0000);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_result !== 8'h00 || bus.out_rd !== 3'd0 || bus.out_wr_en !== 1'b0)
      begin n_err++; $display("FAIL reset_outputs got v=%b r=%h rd=%0d we=%b want all 0", bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_en); end
    n_cmp++; if (status_flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", status_flags); end
  endtask

  task automatic test_single();
    set_in(1'b1, 8'h3C, 3'd3, 1'b1, 1'b1, 4'b0010);
    cycle();
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'b0000);
    cond_sel = 3'b011;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'h3C || bus.out_rd !== 3'd3 || bus.out_wr_en !== 1'b1)
      begin n_err++; $display("FAIL single_head got v=%b r=%h rd=%0d we=%b want 1 3c 3 1", bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_en); end
    n_cmp++; if (status_flags !== 4'b0010) begin n_err++; $display("FAIL single_flags got %b want 0010", status_flags); end
    n_cmp++; if (cond_true !== 1'b1) begin n_err++; $display("FAIL single_cs got %b want 1", cond_true); end
    bus.out_ready = 1'b1;
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_result !== 8'h00) begin n_err++; $display("FAIL single_drain got v=%b r=%h want 0 00", bus.out_valid, bus.out_result); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    set_in(1'b1, 8'h01, 3'd1, 1'b1, 1'b0, 4'b0000); cycle();
    set_in(1'b1, 8'h02, 3'd2, 1'b1, 1'b0, 4'b0000); cycle();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b want 0", bus.in_ready); end
    set_in(1'b1, 8'h03, 3'd3, 1'b0, 1'b0, 4'b0000); cycle();
    n_cmp++; if (bus.out_result !== 8'h01 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold got r=%h v=%b want 01 1", bus.out_result, bus.out_valid); end
    n_cmp++; if (q.size() != 2) begin n_err++; $display("FAIL bp_third_accepted got model depth %0d want 2", q.size()); end
    bus.out_ready = 1'b1;
    cycle();
    n_cmp++; if (bus.out_result !== 8'h02) begin n_err++; $display("FAIL bp_drain2 got %h want 02", bus.out_result); end
    cycle();
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'b0000);
    n_cmp++; if (bus.out_result !== 8'h03 || bus.out_wr_en !== 1'b0) begin n_err++; $display("FAIL bp_drain3 got r=%h we=%b want 03 0", bus.out_result, bus.out_wr_en); end
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 8'(i), 3'(i), 1'b1, 1'b0, 4'b0000);
      cycle();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 8'(i) || bus.in_ready !== 1'b1)
        begin n_err++; $display("FAIL b2b_%0d got v=%b r=%h rdy=%b want 1 %h 1", i, bus.out_valid, bus.out_result, bus.in_ready, 8'(i)); end
    end
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'b0000);
    cycle();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flag_hold();
    bus.out_ready = 1'b1;
    set_in(1'b1, 8'h80, 3'd1, 1'b1, 1'b1, 4'b1000); cycle();
    set_in(1'b1, 8'h7F, 3'd2, 1'b1, 1'b0, 4'b0100); cycle();
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'b0000);
    n_cmp++; if (status_flags !== 4'b1000) begin n_err++; $display("FAIL hold_flags got %b want 1000", status_flags); end
    cond_sel = 3'b111; #1;
    n_cmp++; if (cond_true !== 1'b1) begin n_err++; $display("FAIL hold_lt got %b want 1", cond_true); end
    cond_sel = 3'b110; #1;
    n_cmp++; if (cond_true !== 1'b0) begin n_err++; $display("FAIL hold_vs got %b want 0", cond_true); end
    cycle();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    set_in(1'b1, 8'h11, 3'd1, 1'b1, 1'b1, 4'b0001); cycle();
    set_in(1'b1, 8'h22, 3'd2, 1'b1, 1'b0, 4'b0000); cycle();
    flush = 1'b1;
    set_in(1'b1, 8'h33, 3'd3, 1'b1, 1'b1, 4'b0001);
    cycle();
    flush = 1'b0;
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'b0000);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    n_cmp++; if (status_flags[0] !== 1'b1) begin n_err++; $display("FAIL flush_full_z got %b want 1", status_flags[0]); end
    // Flags cleared, then flush at depth 1 with an accept carrying Z=1 and C=1
    set_in(1'b1, 8'h44, 3'd4, 1'b1, 1'b1, 4'b0000); cycle();
    flush = 1'b1;
    set_in(1'b1, 8'h55, 3'd5, 1'b1, 1'b1, 4'b0011);
    cycle();
    flush = 1'b0;
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'b0000);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_result !== 8'h00) begin n_err++; $display("FAIL flush_accept_discard got v=%b r=%h want 0 00", bus.out_valid, bus.out_result); end
    n_cmp++; if (status_flags !== 4'b0011) begin n_err++; $display("FAIL flush_accept_flags got %b want 0011", status_flags); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    set_in(1'b1, 8'hA1, 3'd6, 1'b1, 1'b1, 4'b1110); cycle();
    set_in(1'b1, 8'hA2, 3'd7, 1'b1, 1'b0, 4'b0000); cycle();
    set_in(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_flags = 4'b0000;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_result !== 8'h00) begin n_err++; $display("FAIL async_rst_out got v=%b r=%h want 0 00", bus.out_valid, bus.out_result); end
    n_cmp++; if (status_flags !== 4'b0000) begin n_err++; $display("FAIL async_rst_flags got %b want 0000", status_flags); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic       ev;
    logic [7:0] er;
    logic [2:0] erd;
    logic       ewe;
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 2) != 0), 8'($urandom), 3'($urandom), 1'($urandom),
             1'($urandom), 4'($urandom));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      cycle();
      cond_sel = 3'($urandom);
      #1;
      ev  = (q.size() != 0);
      er  = ev ? q[0].r  : 8'h00;
      erd = ev ? q[0].rd : 3'd0;
      ewe = ev ? q[0].we : 1'b0;
      n_cmp++;
      if (bus.out_valid !== ev || bus.out_result !== er || bus.out_rd !== erd || bus.out_wr_en !== ewe)
        begin n_err++; $display("FAIL rand_head_%0d got v=%b r=%h rd=%0d we=%b want %b %h %0d %b", i,
          bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr_en, ev, er, erd, ewe); end
      n_cmp++;
      if (bus.in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rand_ready_%0d got %b want %b", i, bus.in_ready, q.size() < 2); end
      n_cmp++;
      if (status_flags !== m_flags || cond_true !== cond_ref(m_flags, cond_sel))
        begin n_err++; $display("FAIL rand_flags_%0d got f=%b c=%b want f=%b c=%b sel=%0d", i,
          status_flags, cond_true, m_flags, cond_ref(m_flags, cond_sel), cond_sel); end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flag_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
